// File: rtl/ni_rd_hist_reader.sv
// Readout sweep for the NI/RD histogram RAMs: read each bin, optionally zero it,
// and stream (idx, ni, rd) beats to the classifier over valid/ready.
module ni_rd_hist_reader #(
  parameter int WIDTH         = 8,
  parameter int SIZED         = 6,
  parameter int DEPTH         = 256,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_rd_en,
  output logic [WIDTH-1:0] o_rd_addr,
  input  logic [SIZED-1:0] i_ni_rdata,
  input  logic [SIZED-1:0] i_rd_rdata,
  output logic             o_clr_en,
  output logic [WIDTH-1:0] o_clr_addr,
  output logic             o_feat_valid,
  input  logic             i_feat_ready,
  output logic [SIZED-1:0] o_feat_ni,
  output logic [SIZED-1:0] o_feat_rd,
  output logic [WIDTH-1:0] o_feat_idx,
  output logic             o_feat_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_REQ = 3'd1;
  localparam logic [2:0] S_RD_CAP = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(DEPTH - 1);
  localparam bit               CLR      = (CLEAR_ON_READ != 0);

  logic [2:0]       state;
  logic [WIDTH-1:0] idx;

  // Termination keys off the captured last flag, so idx never has to wrap
  // even when DEPTH fills the whole address space.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      o_feat_ni   <= '0;
      o_feat_rd   <= '0;
      o_feat_idx  <= '0;
      o_feat_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state <= S_RD_REQ;
            idx   <= '0;
          end
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: begin
          o_feat_ni   <= i_ni_rdata;
          o_feat_rd   <= i_rd_rdata;
          o_feat_idx  <= idx;
          o_feat_last <= (idx == LAST_IDX);
          state       <= S_SEND;
        end
        S_SEND: begin
          if (i_feat_ready) begin
            if (o_feat_last) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_RD_REQ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear rides on the capture cycle, after the read data has been taken.
  assign o_rd_en      = (state == S_RD_REQ);
  assign o_rd_addr    = o_rd_en ? idx : '0;
  assign o_clr_en     = CLR && (state == S_RD_CAP);
  assign o_clr_addr   = o_clr_en ? idx : '0;
  assign o_feat_valid = (state == S_SEND);
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);

endmodule

// File: doc/ni_rd_hist_reader.md
Name: ni_rd_hist_reader

Overview:
- Readout side of the NI/RD histogram memories. The write side increments bins while texture codes arrive.
- When the frame is complete, this block sweeps every bin address and fetches the NI and RD counts from the two histogram RAMs (1-cycle read latency).
- It streams them as a feature vector to the classifier over a valid/ready handshake.
- It can optionally zero each bin after reading, so the histogram is ready for the next frame.

Parameters:
- WIDTH, 8, bin address / index width.
- SIZED, 6, bit width of each bin count.
- DEPTH, 256, number of bins swept; must be ≤ 2^WIDTH and ≥ 1.
- CLEAR_ON_READ, 1, 1 = write zero to each bin after it is captured; 0 = leave memory untouched.

Ports:
- i_clk  in  1  global clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start-sweep request, sampled in IDLE only.
- o_rd_en  out  1  histogram read strobe, shared by both RAMs.
- o_rd_addr  out  WIDTH  histogram read address.
- i_ni_rdata  in  SIZED  NI RAM read data, valid the cycle after o_rd_en.
- i_rd_rdata  in  SIZED  RD RAM read data, valid the cycle after o_rd_en.
- o_clr_en  out  1  write-zero strobe to both RAMs.
- o_clr_addr  out  WIDTH  address to zero.
- o_feat_valid  out  1  feature beat valid.
- i_feat_ready  in  1  downstream ready.
- o_feat_ni  out  SIZED  NI count of current bin.
- o_feat_rd  out  SIZED  RD count of current bin.
- o_feat_idx  out  WIDTH  bin index of current beat.
- o_feat_last  out  1  high on the beat for bin DEPTH-1.
- o_busy  out  1  high from the first RD_REQ cycle through DONE.
- o_done  out  1  one-cycle pulse at sweep end.

Behaviour:
- Reset (async assert, synchronous release): state = IDLE; index counter = 0.
  - All outputs are 0: o_rd_en, o_rd_addr, o_clr_en, o_clr_addr, o_feat_valid, o_feat_ni, o_feat_rd, o_feat_idx, o_feat_last, o_busy, o_done.
- FSM states: IDLE, RD_REQ, RD_CAP, SEND, DONE.
- IDLE: if i_start = 1, go to RD_REQ with idx = 0. Otherwise stay.
- RD_REQ: o_rd_en = 1 and o_rd_addr = idx (combinational from state and idx). Go to RD_CAP.
- RD_CAP:
  - Register i_ni_rdata → o_feat_ni, i_rd_rdata → o_feat_rd, idx → o_feat_idx, and (idx == DEPTH-1) → o_feat_last.
  - If CLEAR_ON_READ = 1: o_clr_en = 1 and o_clr_addr = idx in this same cycle. Otherwise o_clr_en stays 0.
  - Go to SEND.
- SEND:
  - o_feat_valid = 1. Data, idx and last are held stable until the handshake.
  - On i_feat_ready = 1: if last, go to DONE; else idx ← idx + 1 and go to RD_REQ.
  - Without ready, stay in SEND indefinitely.
- DONE: o_done = 1 for exactly one cycle, then IDLE. o_busy is still 1 in DONE and falls in IDLE.
- Per-bin cost is 3 cycles with ready held high. Full sweep is 3·DEPTH cycles plus 1 DONE cycle.
- Timing example (start sampled at edge 0):
  - RD_REQ in cycle 1.
  - First valid beat in cycle 3.
  - o_done in cycle 3·DEPTH+1.
- i_start while o_busy = 1 is ignored, with no restart or queuing. i_start held high across DONE→IDLE starts a new sweep on the following cycle.
- Index counter is WIDTH bits and never exceeds DEPTH-1. When DEPTH = 2^WIDTH, the terminal condition is the last flag, not counter wrap.
- Clear writes are issued only after capture, so a bin is never zeroed before its value is read.
- The write side must hold its update enable low while o_busy = 1. This block does not check it.
- Reset asserted mid-sweep: immediate return to IDLE. No o_done pulse; a partially-cleared memory is acceptable.
- Downstream drops i_feat_ready mid-sweep: no data change and no extra RAM reads or clears.

Test Plan:
- DEPTH=4, CLEAR_ON_READ=1, NI RAM = {3,0,63,5}, RD RAM = {1,2,0,63}, ready tied 1, pulse i_start.
  - Beats (idx,ni,rd) = (0,3,1), (1,0,2), (2,63,0), (3,5,63) in cycles 3, 6, 9, 12.
  - o_feat_last only on idx 3; o_done in cycle 13.
  - Both RAMs all 0 afterwards.
- Same setup with CLEAR_ON_READ=0 → identical beats, o_clr_en never asserts, RAM contents unchanged.
- Backpressure: i_feat_ready low for 5 cycles during beat idx=1.
  - o_feat_valid stays 1 with ni=0, rd=2 stable.
  - o_rd_en not asserted during the stall.
  - Sweep finishes 5 cycles later than in the first test.
- i_start pulsed again at cycle 5 of a sweep → ignored. Exactly 4 beats and 1 o_done.
- Reset asserted at cycle 7 → all outputs 0 within the same cycle (async), FSM in IDLE, no o_done. A new i_start then restarts at idx=0.
- DEPTH=256, WIDTH=8, random RAM contents, random ready → 256 beats in index order matching memory, last on idx 255, counter never wraps to a 257th beat.
